// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid stage state encoding and the
// per-boundary payload widths used when instantiating pipe_skid_stage.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } pipe_st_e;

   localparam int unsigned IF_ID_W  = 64;
   localparam int unsigned ID_EX_W  = 128;
   localparam int unsigned EX_MEM_W = 96;
   localparam int unsigned MEM_WB_W = 72;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and
// synchronous flush. Define PIPE_SKID_PERF_EN to add stall/bubble counters.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
  ,input  logic             perf_clr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   pipe_st_e         state_q, state_nxt;
   logic [WIDTH-1:0] main_q, main_nxt;
   logic [WIDTH-1:0] skid_q, skid_nxt;
   logic             in_ready_q;
   logic             in_xfer, out_xfer;

   assign out_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
   assign in_ready  = in_ready_q;
   assign out_data  = main_q;
   assign in_xfer   = in_valid & in_ready_q;
   assign out_xfer  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_EMPTY;
         main_q     <= RESET_VAL;
         skid_q     <= RESET_VAL;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_nxt;
         main_q     <= main_nxt;
         skid_q     <= skid_nxt;
         in_ready_q <= (state_nxt != ST_FULL);
      end
   end

   always_comb begin
      state_nxt = state_q;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         // Squash wins: any accepted input this cycle is dropped.
         state_nxt = ST_EMPTY;
         main_nxt  = RESET_VAL;
         skid_nxt  = RESET_VAL;
      end else begin
         case (state_q)
            ST_BUSY: begin
               if (in_xfer && out_xfer) begin
                  main_nxt = in_data;
               end else if (in_xfer) begin
                  skid_nxt  = in_data;
                  state_nxt = ST_FULL;
               end else if (out_xfer) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // Skid entry is older than anything upstream, so it moves up first.
               if (out_xfer) begin
                  main_nxt  = skid_q;
                  skid_nxt  = RESET_VAL;
                  state_nxt = ST_BUSY;
               end
            end
            default: begin
               if (in_xfer) begin
                  main_nxt  = in_data;
                  state_nxt = ST_BUSY;
               end else begin
                  state_nxt = ST_EMPTY;
               end
            end
         endcase
      end
   end

`ifdef PIPE_SKID_PERF_EN
   pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (out_valid & ~out_ready),
      .clr (perf_clr),
      .cnt (stall_cnt)
   );

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (~out_valid),
      .clr (perf_clr),
      .cnt (bubble_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference.
module tb_pipe_skid_stage;

   localparam int unsigned      W     = 16;
   localparam int unsigned      CW    = 4;
   localparam logic [W-1:0]     RV    = 16'h0F0F;
   localparam int unsigned      N_RND = 10000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
`ifdef PIPE_SKID_PERF_EN
   logic          perf_clr = 1'b0;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] bubble_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
     ,.perf_clr  (perf_clr),
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic         iv;
      logic         ordy;
      logic         fl;
      logic [W-1:0] d;
      logic         e_ov;
      logic         e_ir;
      logic [W-1:0] e_od;
   } vec_t;

   vec_t vecs[13];

   logic [W-1:0] q[$];
   logic         ir_m, ov_m;
   int           stall_m, bubble_m;
   logic         pclr;

   initial begin
      // iv  ordy fl  data      ov  ir  out_data
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b1, 16'hAAAA};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'hBBBB, 1'b1, 1'b0, 16'hAAAA};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'hCCCC, 1'b1, 1'b0, 16'hAAAA};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hBBBB};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hBBBB};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b1, 16'h1111};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h2222, 1'b1, 1'b0, 16'h1111};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'hCCCC, 1'b0, 1'b1, RV};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, RV};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h3333, 1'b1, 1'b1, 16'h3333};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b1, 16'h4444};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b1, RV};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, RV};

      // Reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", 32'(out_data), 32'(RV));
`ifdef PIPE_SKID_PERF_EN
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Directed table: backpressure, skid fill/drain, flush in FULL and BUSY
      for (int i = 0; i < 13; i++) begin
         in_valid  = vecs[i].iv;
         out_ready = vecs[i].ordy;
         flush     = vecs[i].fl;
         in_data   = vecs[i].d;
         tick();
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
         chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      end
      flush = 1'b0;

      // Streaming at full throughput
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = W'(i);
         tick();
         chk($sformatf("stream%0d_out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("stream%0d_out_data", i), 32'(out_data), 32'(i));
         chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain_out_valid", 32'(out_valid), 32'd0);

      // Async reset mid-cycle while BUSY
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h1234;
      tick();
      chk("areset_pre_out_data", 32'(out_data), 32'h1234);
      in_valid = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      chk("areset_out_valid", 32'(out_valid), 32'd0);
      chk("areset_out_data", 32'(out_data), 32'(RV));
      chk("areset_in_ready", 32'(in_ready), 32'd1);
      #2;
      rst = 1'b1;
      tick();
      chk("areset_post_out_valid", 32'(out_valid), 32'd0);

`ifdef PIPE_SKID_PERF_EN
      // Stall counter saturation, flush leaves counters, perf_clr clears
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      chk("perf_clr0_stall", 32'(stall_cnt), 32'd0);
      chk("perf_clr0_bubble", 32'(bubble_cnt), 32'd0);
      in_valid = 1'b1;
      in_data  = 16'h7777;
      tick();
      in_valid = 1'b0;
      chk("perf_load_stall", 32'(stall_cnt), 32'd0);
      chk("perf_load_bubble", 32'(bubble_cnt), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      chk("perf_stall5", 32'(stall_cnt), 32'd5);
      for (int i = 0; i < 15; i++) tick();
      chk("perf_stall_sat", 32'(stall_cnt), 32'd15);
      chk("perf_hold_data", 32'(out_data), 32'h7777);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("perf_flush_keeps", 32'(stall_cnt), 32'd15);
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      chk("perf_clr_stall", 32'(stall_cnt), 32'd0);
      chk("perf_clr_bubble", 32'(bubble_cnt), 32'd0);
`endif

      // Random traffic vs. queue model (stage holds at most two items)
      q.delete();
      while (!(out_valid === 1'b0)) begin
         out_ready = 1'b1;
         tick();
      end
      stall_m  = 0;
      bubble_m = 0;
      pclr     = 1'b1;
`ifdef PIPE_SKID_PERF_EN
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
`endif
      for (int c = 0; c < N_RND; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_data   = W'($urandom);
         pclr      = ($urandom_range(0, 63) == 0);
`ifdef PIPE_SKID_PERF_EN
         perf_clr  = pclr;
`endif
         ir_m = (q.size() < 2);
         ov_m = (q.size() > 0);
         if (pclr) begin
            stall_m  = 0;
            bubble_m = 0;
         end else begin
            if (ov_m && !out_ready) stall_m = (stall_m < 15) ? stall_m + 1 : 15;
            if (!ov_m) bubble_m = (bubble_m < 15) ? bubble_m + 1 : 15;
         end
         if (flush) begin
            q.delete();
         end else begin
            if (ov_m && out_ready) void'(q.pop_front());
            if (in_valid && ir_m) q.push_back(in_data);
         end
         tick();
         chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
         if (q.size() > 0) chk("rnd_out_data", 32'(out_data), 32'(q[0]));
`ifdef PIPE_SKID_PERF_EN
         chk("rnd_stall_cnt", 32'(stall_cnt), 32'(stall_m));
         chk("rnd_bubble_cnt", 32'(bubble_cnt), 32'(bubble_m));
`endif
      end
      flush    = 1'b0;
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
